load_queue: RTL

//  In-order circular queue of dispatched loads; requester side of the store-queue forwarding interface.
//  - Each cycle, probes the store queue with the oldest address-ready load.
//  - On a forward hit, takes the store data.
//  - On a miss, issues the load to the D-cache and accepts tagged, out-of-order responses.
//  - Broadcasts completed loads one per cycle; frees entries in order on retire.

---
 rtl/load_queue_if.sv | 53 +++++
 rtl/load_queue.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/load_queue_if.sv
// load_queue_if: bus bundle between the load queue and its store-queue, D-cache and completion partners.
//   Store-queue forwarding probe
//     sq_rd_en, sq_addr_rd, sq_ld_pos       : load queue -> store queue
//     sq_data_rd, sq_rd_valid, sq_data_stall: store queue -> load queue, same cycle
//   D-cache read port
//     mem_req_valid, mem_req_addr, mem_req_tag  : load queue -> cache
//     mem_req_ready                             : cache -> load queue
//     mem_resp_valid, mem_resp_tag, mem_resp_data: cache -> load queue, out of order
//   Completion broadcast
//     cmpl_valid, cmpl_tag, cmpl_data : load queue -> consumers
//     cmpl_ready                      : consumers -> load queue
//   Modports: master = load queue side, slave = environment side.
interface load_queue_if #(
    parameter int IDX_W    = 3,
    parameter int SQ_IDX_W = 3,
    parameter int TAG_W    = 6
);
    logic                sq_rd_en;
    logic [31:0]         sq_addr_rd;
    logic [SQ_IDX_W-1:0] sq_ld_pos;
    logic [63:0]         sq_data_rd;
    logic                sq_rd_valid;
    logic                sq_data_stall;
    logic                mem_req_valid;
    logic [31:0]         mem_req_addr;
    logic [IDX_W:0]      mem_req_tag;
    logic                mem_req_ready;
    logic                mem_resp_valid;
    logic [IDX_W:0]      mem_resp_tag;
    logic [63:0]         mem_resp_data;
    logic                cmpl_valid;
    logic [TAG_W-1:0]    cmpl_tag;
    logic [63:0]         cmpl_data;
    logic                cmpl_ready;

    modport master (
        output sq_rd_en, sq_addr_rd, sq_ld_pos,
        input  sq_data_rd, sq_rd_valid, sq_data_stall,
        output mem_req_valid, mem_req_addr, mem_req_tag,
        input  mem_req_ready, mem_resp_valid, mem_resp_tag, mem_resp_data,
        output cmpl_valid, cmpl_tag, cmpl_data,
        input  cmpl_ready
    );

    modport slave (
        input  sq_rd_en, sq_addr_rd, sq_ld_pos,
        output sq_data_rd, sq_rd_valid, sq_data_stall,
        input  mem_req_valid, mem_req_addr, mem_req_tag,
        output mem_req_ready, mem_resp_valid, mem_resp_tag, mem_resp_data,
        input  cmpl_valid, cmpl_tag, cmpl_data,
        output cmpl_ready
    );
endinterface

// File: rtl/load_queue.sv
// load_queue: in-order circular queue of dispatched loads with store-queue forwarding and out-of-order D-cache responses.
//   clock, reset                 : clock, synchronous active-high reset
//   flush_i                      : branch-mispredict flush (only when LQ_FLUSH_EN is defined)
//   dispatch_en_i/tag/sq_pos/addr/addr_ready : load dispatch
//   ex_en_i, ex_index_i, ex_addr_i           : address generation for a waiting entry
//   rt_en_i                      : retire the head entry
//   lq                           : load_queue_if.master (SQ probe, D-cache port, completion broadcast)
//   lq_tail_out_o                : index given to a load dispatched this cycle
//   full_o                       : (tail+1)==head from registered pointers
//   Macro LQ_FLUSH_EN adds flush_i and epoch toggling; without it the epoch stays 0.
module load_queue #(
    parameter int  LQ_SIZE  = 8,
    parameter int  SQ_IDX_W = 3,
    parameter int  TAG_W    = 6,
    localparam int IDX_W    = $clog2(LQ_SIZE)
) (
    input  logic                clock,
    input  logic                reset,
`ifdef LQ_FLUSH_EN
    input  logic                flush_i,
`endif
    input  logic                dispatch_en_i,
    input  logic [TAG_W-1:0]    dispatch_tag_i,
    input  logic [SQ_IDX_W-1:0] dispatch_sq_pos_i,
    input  logic [31:0]         dispatch_addr_i,
    input  logic                dispatch_addr_ready_i,
    input  logic                ex_en_i,
    input  logic [IDX_W-1:0]    ex_index_i,
    input  logic [31:0]         ex_addr_i,
    input  logic                rt_en_i,
    load_queue_if.master        lq,
    output logic [IDX_W-1:0]    lq_tail_out_o,
    output logic                full_o
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT_ADDR, S_READY, S_MEM_WAIT, S_DONE, S_CMPL} state_e;

    state_e              st_q   [LQ_SIZE];
    state_e              st_d   [LQ_SIZE];
    logic [31:0]         addr_q [LQ_SIZE];
    logic [31:0]         addr_d [LQ_SIZE];
    logic [63:0]         data_q [LQ_SIZE];
    logic [63:0]         data_d [LQ_SIZE];
    logic [TAG_W-1:0]    tag_q  [LQ_SIZE];
    logic [TAG_W-1:0]    tag_d  [LQ_SIZE];
    logic [SQ_IDX_W-1:0] pos_q  [LQ_SIZE];
    logic [SQ_IDX_W-1:0] pos_d  [LQ_SIZE];
    logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic                epoch_q, epoch_d;
    // Completion lock: keeps the broadcast entry fixed while a consumer stalls,
    // even if an older entry becomes DONE in the meantime.
    logic                hold_q, hold_d;
    logic [IDX_W-1:0]    hold_idx_q, hold_idx_d;
    logic                prb_v, cmp_v;
    logic [IDX_W-1:0]    prb_idx, cmp_idx, scan, resp_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LQ_SIZE; i++) st_q[i] <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            epoch_q    <= 1'b0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            st_q       <= st_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            epoch_q    <= epoch_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
        tag_q  <= tag_d;
        pos_q  <= pos_d;
    end

    assign resp_idx = lq.mem_resp_tag[IDX_W-1:0];

    // Event order within a cycle: retire, ex, mem response, probe, completion, dispatch, flush overrides all.
    always_comb begin
        st_d       = st_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tag_d      = tag_q;
        pos_d      = pos_q;
        head_d     = head_q;
        tail_d     = tail_q;
        epoch_d    = epoch_q;
        hold_d     = lq.cmpl_valid & ~lq.cmpl_ready;
        hold_idx_d = cmp_idx;
        if (rt_en_i && st_q[head_q] == S_CMPL) begin
            st_d[head_q] = S_IDLE;
            head_d       = head_q + 1'b1;
        end
        if (ex_en_i && st_q[ex_index_i] == S_WAIT_ADDR) begin
            st_d[ex_index_i]   = S_READY;
            addr_d[ex_index_i] = ex_addr_i;
        end
        if (lq.mem_resp_valid && lq.mem_resp_tag[IDX_W] == epoch_q && st_q[resp_idx] == S_MEM_WAIT) begin
            st_d[resp_idx]   = S_DONE;
            data_d[resp_idx] = lq.mem_resp_data;
        end
        if (prb_v && !lq.sq_data_stall) begin
            if (lq.sq_rd_valid) begin
                st_d[prb_idx]   = S_DONE;
                data_d[prb_idx] = lq.sq_data_rd;
            end else if (lq.mem_req_ready) begin
                st_d[prb_idx] = S_MEM_WAIT;
            end
        end
        if (lq.cmpl_valid && lq.cmpl_ready) st_d[cmp_idx] = S_CMPL;
        if (dispatch_en_i && !full_o) begin
            st_d[tail_q]   = dispatch_addr_ready_i ? S_READY : S_WAIT_ADDR;
            addr_d[tail_q] = dispatch_addr_i;
            tag_d[tail_q]  = dispatch_tag_i;
            pos_d[tail_q]  = dispatch_sq_pos_i;
            tail_d         = tail_q + 1'b1;
        end
`ifdef LQ_FLUSH_EN
        if (flush_i) begin
            for (int i = 0; i < LQ_SIZE; i++) st_d[i] = S_IDLE;
            head_d  = '0;
            tail_d  = '0;
            epoch_d = ~epoch_q;
            hold_d  = 1'b0;
        end
`endif
    end

    // Oldest-first selection: scan from youngest offset down so the oldest match is written last.
    always_comb begin
        prb_v   = 1'b0;
        prb_idx = '0;
        cmp_v   = 1'b0;
        cmp_idx = '0;
        scan    = '0;
        for (int i = LQ_SIZE - 1; i >= 0; i--) begin
            scan = head_q + IDX_W'(i);
            if (st_q[scan] == S_READY) begin
                prb_v   = 1'b1;
                prb_idx = scan;
            end
            if (st_q[scan] == S_DONE) begin
                cmp_v   = 1'b1;
                cmp_idx = scan;
            end
        end
        cmp_idx = hold_q ? hold_idx_q : cmp_idx;
        cmp_v   = hold_q | cmp_v;
    end

    always_comb begin
        lq.sq_rd_en      = prb_v;
        lq.sq_addr_rd    = addr_q[prb_idx];
        lq.sq_ld_pos     = prb_v ? pos_q[prb_idx] : '0;
        lq.mem_req_valid = prb_v & ~lq.sq_data_stall & ~lq.sq_rd_valid;
        lq.mem_req_addr  = addr_q[prb_idx];
        lq.mem_req_tag   = lq.mem_req_valid ? {epoch_q, prb_idx} : '0;
        lq.cmpl_valid    = cmp_v;
        lq.cmpl_tag      = tag_q[cmp_idx];
        lq.cmpl_data     = data_q[cmp_idx];
        lq_tail_out_o    = tail_q;
        full_o           = (tail_q + 1'b1) == head_q;
    end
endmodule
